// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a ready/valid load port and a shift enable.
// Define BIT_SERIALIZER_LSB_FIRST_EN to shift LSB first (the default is MSB first).
module bit_serializer #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             dout,
   output logic             dout_valid,
   output logic             last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $error("bit_serializer: WIDTH must be in 2..32");
      end
   endgenerate

   logic [0:0]       state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;

   logic             accept;
   logic             advance;
   logic             finish;
   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] load_rest;
   logic [WIDTH-1:0] shift_rest;

   // The first bit goes straight to dout on acceptance; shift_reg holds the
   // remaining bits, pre-shifted so the next bit always sits at the exit end.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   assign first_bit  = data_in[0];
   assign load_rest  = data_in >> 1;
   assign next_bit   = shift_reg[0];
   assign shift_rest = shift_reg >> 1;
`else
   assign first_bit  = data_in[WIDTH-1];
   assign load_rest  = data_in << 1;
   assign next_bit   = shift_reg[WIDTH-1];
   assign shift_rest = shift_reg << 1;
`endif

   assign load_ready = rst && ((state == S_IDLE) || (last && shift_en));
   assign accept     = load_valid && load_ready;
   assign advance    = (state == S_SHIFT) && shift_en && !last;
   assign finish     = (state == S_SHIFT) && shift_en && last;
   assign busy       = (state == S_SHIFT);

   // A load on the final-bit edge wins over returning to IDLE, giving back-to-back words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
         last       <= 1'b0;
      end else if (accept) begin
         state      <= S_SHIFT;
         bit_cnt    <= '0;
         shift_reg  <= load_rest;
         dout       <= first_bit;
         dout_valid <= 1'b1;
         last       <= 1'b0;
      end else if (advance) begin
         bit_cnt    <= (bit_cnt == LAST_IDX) ? bit_cnt : bit_cnt + CW'(1);
         shift_reg  <= shift_rest;
         dout       <= next_bit;
         last       <= (bit_cnt == PEN_IDX);
      end else if (finish) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
         last       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8): directed scenarios plus
// randomized load/shift traffic against a word/bit-index reference model.
module tb_bit_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       load_valid;
   logic       load_ready;
   logic       shift_en;
   logic       dout;
   logic       dout_valid;
   logic       last;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   logic        m_busy;
   logic [7:0]  m_word;
   int          m_pos;

   logic        capture;
   logic [31:0] stream;
   int          stream_len;

   bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .shift_en   (shift_en),
      .dout       (dout),
      .dout_valid (dout_valid),
      .last       (last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic expBit();
      if (!m_busy) return 1'b1;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      return m_word[m_pos];
`else
      return m_word[7 - m_pos];
`endif
   endfunction

   task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task checkModel();
      checkOutput("dout", {31'd0, dout}, {31'd0, expBit()});
      checkOutput("dout_valid", {31'd0, dout_valid}, {31'd0, m_busy});
      checkOutput("last", {31'd0, last}, {31'd0, (m_busy && m_pos == 7)});
      checkOutput("busy", {31'd0, busy}, {31'd0, m_busy});
   endtask

   // One clock cycle: drive inputs, check load_ready, clock, update model, check outputs.
   task applyStimulus(input logic lv, input logic [7:0] d, input logic se);
      logic exp_ready;
      logic acc;
      load_valid = lv;
      data_in    = d;
      shift_en   = se;
      #1;
      exp_ready = !m_busy || (m_pos == 7 && se);
      checkOutput("load_ready", {31'd0, load_ready}, {31'd0, exp_ready});
      acc = lv && exp_ready;
      @(posedge clk);
      if (acc) begin
         m_busy = 1'b1;
         m_word = d;
         m_pos  = 0;
      end else if (m_busy && se) begin
         if (m_pos == 7) m_busy = 1'b0;
         else m_pos++;
      end
      #1;
      checkModel();
      if (capture && dout_valid) begin
         stream = {stream[30:0], dout};
         stream_len++;
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task pulseReset();
      load_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      m_busy = 1'b0;
      m_pos  = 0;
      checkModel();
      checkOutput("reset_ready", {31'd0, load_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task startCapture();
      capture    = 1'b1;
      stream     = '0;
      stream_len = 0;
   endtask

   initial begin
      logic [7:0] rnd_data;
      logic       rnd_lv;
      logic       rnd_se;

      rst        = 1'b0;
      load_valid = 1'b0;
      shift_en   = 1'b0;
      data_in    = '0;
      m_busy     = 1'b0;
      m_word     = '0;
      m_pos      = 0;
      capture    = 1'b0;
      stream     = '0;
      stream_len = 0;

      repeat (2) @(posedge clk);
      #1;
      checkModel();
      checkOutput("reset_ready", {31'd0, load_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 8'hA8 accepted on the very first edge after reset release.
      startCapture();
      applyStimulus(1'b1, 8'hA8, 1'b1);
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);
      capture = 1'b0;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      checkOutput("stream_a8", {24'd0, stream[7:0]}, 32'h15);
`else
      checkOutput("stream_a8", {24'd0, stream[7:0]}, 32'hA8);
`endif
      checkOutput("len_a8", stream_len, 8);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Back-to-back words: 8'h0F loaded on the last bit of 8'hF0.
      startCapture();
      applyStimulus(1'b1, 8'hF0, 1'b1);
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b1, 8'h0F, 1'b1);
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);
      capture = 1'b0;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      checkOutput("stream_f00f", {16'd0, stream[15:0]}, 32'h0FF0);
`else
      checkOutput("stream_f00f", {16'd0, stream[15:0]}, 32'hF00F);
`endif
      checkOutput("len_f00f", stream_len, 16);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Stall for three cycles while the second bit of 8'hC3 is on dout.
      applyStimulus(1'b1, 8'hC3, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (3) begin
         applyStimulus(1'b0, 8'h00, 1'b0);
         checkOutput("stall_dout", {31'd0, dout}, 32'd1);
      end
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);

      // load_valid held high before last must not disturb the word in flight.
      applyStimulus(1'b1, 8'h3C, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(i * 37 + 5), 1'b1);
      applyStimulus(1'b0, 8'hFF, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Reset mid-word of 8'h55, then a clean 8'hFF.
      applyStimulus(1'b1, 8'h55, 1'b1);
      repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
      pulseReset();
      applyStimulus(1'b0, 8'h00, 1'b1);
      startCapture();
      applyStimulus(1'b1, 8'hFF, 1'b1);
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);
      capture = 1'b0;
      checkOutput("stream_ff", {24'd0, stream[7:0]}, 32'hFF);
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Bit order check with a single set bit.
      startCapture();
      applyStimulus(1'b1, 8'h01, 1'b1);
      repeat (7) applyStimulus(1'b0, 8'h00, 1'b1);
      capture = 1'b0;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      checkOutput("stream_01", {24'd0, stream[7:0]}, 32'h80);
`else
      checkOutput("stream_01", {24'd0, stream[7:0]}, 32'h01);
`endif
      applyStimulus(1'b0, 8'h00, 1'b1);

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 600; n++) begin
         rnd_data = 8'($urandom);
         rnd_lv   = ($urandom_range(0, 1) == 1);
         rnd_se   = ($urandom_range(0, 3) != 0);
         applyStimulus(rnd_lv, rnd_data, rnd_se);
         if ($urandom_range(0, 99) == 0) pulseReset();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
